systolic_mac_pe: RTL and testbench

SYSTOLIC_MAC_PE -- requirements
Module: systolic_mac_pe

---
 rtl/systolic_mac_pe.sv | 137 +++++++++++++
 tb/tb_systolic_mac_pe.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_pe.sv
// Systolic-array MAC processing element: activations flow east, partial sums flow south,
// weights are double-buffered (shadow/active) and daisy-chained south one PE per cycle.
module systolic_mac_pe #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [ACC_W-1:0]  in_sum,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_load,
  input  logic              w_swap,
  input  logic              clear_ovf,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] w_out,
  output logic              w_active_valid,
  output logic              ovf
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_SHADOW = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_PEND   = 2'd3;
  localparam logic       SGN       = (SIGNED != 0);
  localparam logic       SAT       = (SATURATE != 0);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [DATA_W-1:0]   r_w_shadow;
  logic [DATA_W-1:0]   r_w_active;
  logic [DATA_W-1:0]   r_w_out;
  logic                w_has_shadow;
  logic                w_swap_ok;

  logic [DATA_W-1:0]   w_wgt_p0;
  logic [2*DATA_W-1:0] w_a_ext_p0;
  logic [2*DATA_W-1:0] w_w_ext_p0;
  logic [2*DATA_W-1:0] w_prod_p0;
  logic [ACC_W:0]      w_prod_ext_p0;
  logic [ACC_W:0]      w_sum_ext_p0;
  logic signed [ACC_W:0] w_sum_p0;
  logic                w_ovf_p0;

  logic [DATA_W-1:0]   r_data_p1;
  logic [ACC_W-1:0]    r_sum_p1;
  logic                r_vld_p1;
  logic                r_ovf;

  // True sum is carried at ACC_W+1 bits, so it never wraps before this test.
  function automatic logic ovf_fn(input logic [ACC_W:0] s);
    if (SGN) return s[ACC_W] != s[ACC_W-1];
    return s[ACC_W];
  endfunction

  function automatic logic [ACC_W-1:0] sat_fn(input logic [ACC_W:0] s);
    if (SAT && ovf_fn(s)) begin
      if (!SGN)          return '1;
      else if (s[ACC_W]) return {1'b1, {(ACC_W-1){1'b0}}};
      else               return {1'b0, {(ACC_W-1){1'b1}}};
    end
    return s[ACC_W-1:0];
  endfunction

  assign w_has_shadow   = (r_state == ST_SHADOW) || (r_state == ST_PEND);
  assign w_swap_ok      = w_swap && w_has_shadow;
  assign w_active_valid = (r_state == ST_ACTIVE) || (r_state == ST_PEND);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY:  if (w_load) w_state_nxt = ST_SHADOW;
      ST_SHADOW: if (w_swap) w_state_nxt = w_load ? ST_PEND : ST_ACTIVE;
      ST_ACTIVE: if (w_load) w_state_nxt = ST_PEND;
      ST_PEND:   if (w_swap && !w_load) w_state_nxt = ST_ACTIVE;
      default:   w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_w_shadow <= '0;
      r_w_active <= '0;
      r_w_out    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_swap_ok) r_w_active <= r_w_shadow;
      if (w_load) begin
        r_w_shadow <= w_in;
        r_w_out    <= w_in;
      end
    end
  end

  // Stage p0: multiply by the pre-edge active weight, extend and add.
  always_comb begin
    w_wgt_p0      = w_active_valid ? r_w_active : '0;
    w_a_ext_p0    = {{DATA_W{SGN & in_data[DATA_W-1]}}, in_data};
    w_w_ext_p0    = {{DATA_W{SGN & w_wgt_p0[DATA_W-1]}}, w_wgt_p0};
    w_prod_p0     = w_a_ext_p0 * w_w_ext_p0;
    w_prod_ext_p0 = {{(ACC_W+1-2*DATA_W){SGN & w_prod_p0[2*DATA_W-1]}}, w_prod_p0};
    w_sum_ext_p0  = {SGN & in_sum[ACC_W-1], in_sum};
    w_sum_p0      = $signed(w_sum_ext_p0 + w_prod_ext_p0);
    w_ovf_p0      = ovf_fn(w_sum_p0);
  end

  // Stage p1: registered outputs toward east/south.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_p1 <= '0;
      r_sum_p1  <= '0;
      r_vld_p1  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_data_p1 <= in_data;
        r_sum_p1  <= sat_fn(w_sum_p0);
      end
      if (in_valid && w_ovf_p0) r_ovf <= 1'b1;
      else if (clear_ovf)       r_ovf <= 1'b0;
    end
  end

  assign out_data  = r_data_p1;
  assign out_sum   = r_sum_p1;
  assign out_valid = r_vld_p1;
  assign w_out     = r_w_out;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: three instances (signed/sat, signed/wrap, unsigned/sat) driven
// in lockstep and compared against an arithmetic reference model after every clock.
module tb_systolic_mac_pe;
  localparam int DW = 8;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset, in_valid, w_load, w_swap, clear_ovf;
  logic [DW-1:0] in_data, w_in;
  logic [AW-1:0] in_sum;

  logic [DW-1:0] o_data [3];
  logic          o_vld  [3];
  logic [AW-1:0] o_sum  [3];
  logic [DW-1:0] o_wout [3];
  logic          o_wav  [3];
  logic          o_ovf  [3];

  int checks = 0;
  int errors = 0;

  // Reference state: weights as values plus presence flags.
  logic [DW-1:0] m_sh, m_act, m_wout, m_data;
  logic          m_has_sh, m_has_act, m_vld;
  logic [AW-1:0] m_sum [3];
  logic          m_ovf [3];

  always #5 clk = ~clk;

  systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sum(in_sum),
    .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .clear_ovf(clear_ovf),
    .out_data(o_data[0]), .out_valid(o_vld[0]), .out_sum(o_sum[0]), .w_out(o_wout[0]),
    .w_active_valid(o_wav[0]), .ovf(o_ovf[0]));

  systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sum(in_sum),
    .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .clear_ovf(clear_ovf),
    .out_data(o_data[1]), .out_valid(o_vld[1]), .out_sum(o_sum[1]), .w_out(o_wout[1]),
    .w_active_valid(o_wav[1]), .ovf(o_ovf[1]));

  systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(0), .SATURATE(1)) u_uns (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sum(in_sum),
    .w_in(w_in), .w_load(w_load), .w_swap(w_swap), .clear_ovf(clear_ovf),
    .out_data(o_data[2]), .out_valid(o_vld[2]), .out_sum(o_sum[2]), .w_out(o_wout[2]),
    .w_active_valid(o_wav[2]), .ovf(o_ovf[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k=0 signed saturating, k=1 signed wrapping, k=2 unsigned saturating.
  function automatic void mdl(input int k, input logic [DW-1:0] d, input logic [DW-1:0] w,
                              input logic [AW-1:0] s, output logic [AW-1:0] r, output logic o);
    longint t, lo, hi;
    if (k != 2) begin
      t  = longint'($signed(s)) + longint'($signed(d)) * longint'($signed(w));
      lo = -(longint'(1) << (AW-1));
      hi = (longint'(1) << (AW-1)) - 1;
    end else begin
      t  = longint'(s) + longint'(d) * longint'(w);
      lo = 0;
      hi = (longint'(1) << AW) - 1;
    end
    o = (t < lo) || (t > hi);
    if (o && k != 1) t = (t > hi) ? hi : lo;
    r = t[AW-1:0];
  endfunction

  task automatic step(input logic rst, input logic v, input logic [DW-1:0] d,
                      input logic [AW-1:0] s, input logic ld, input logic sw,
                      input logic [DW-1:0] wi, input logic clr);
    logic [AW-1:0] r;
    logic          o;
    reset = rst; in_valid = v; in_data = d; in_sum = s;
    w_load = ld; w_swap = sw; w_in = wi; clear_ovf = clr;
    if (rst) begin
      m_sh = '0; m_act = '0; m_wout = '0; m_data = '0;
      m_has_sh = 1'b0; m_has_act = 1'b0; m_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin m_sum[k] = '0; m_ovf[k] = 1'b0; end
    end else begin
      m_vld = v;
      if (v) m_data = d;
      for (int k = 0; k < 3; k++) begin
        mdl(k, d, m_has_act ? m_act : '0, s, r, o);
        if (v) m_sum[k] = r;
        if (v && o)   m_ovf[k] = 1'b1;
        else if (clr) m_ovf[k] = 1'b0;
      end
      if (sw && m_has_sh) begin m_act = m_sh; m_has_act = 1'b1; m_has_sh = 1'b0; end
      if (ld) begin m_sh = wi; m_has_sh = 1'b1; m_wout = wi; end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_sum[%0d]", k), 32'(o_sum[k]), 32'(m_sum[k]));
      chk($sformatf("out_valid[%0d]", k), 32'(o_vld[k]), 32'(m_vld));
      chk($sformatf("out_data[%0d]", k), 32'(o_data[k]), 32'(m_data));
      chk($sformatf("w_out[%0d]", k), 32'(o_wout[k]), 32'(m_wout));
      chk($sformatf("w_active_valid[%0d]", k), 32'(o_wav[k]), 32'(m_has_act));
      chk($sformatf("ovf[%0d]", k), 32'(o_ovf[k]), 32'(m_ovf[k]));
    end
  endtask

  initial begin
    logic [AW-1:0] rs;
    int            sel;
    // Reset and no-weight pass-through
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_sum", 32'(o_sum[0]), 32'h0);
    chk("reset_wav", 32'(o_wav[0]), 32'h0);
    step(0, 1, 8'd5, 20'd7, 0, 0, 0, 0);
    chk("noweight_sum", 32'(o_sum[0]), 32'd7);
    chk("noweight_vld", 32'(o_vld[0]), 32'd1);
    chk("noweight_wav", 32'(o_wav[0]), 32'd0);
    // Load -3, swap, multiply
    step(0, 0, 0, 0, 1, 0, 8'hFD, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 8'd4, 20'd100, 0, 0, 0, 0);
    chk("neg_weight_sum", 32'(o_sum[0]), 32'd88);
    chk("neg_weight_wout", 32'(o_wout[0]), 32'hFD);
    chk("neg_weight_wav", 32'(o_wav[0]), 32'd1);
    // Load+swap+valid in one cycle uses the old weight
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 8'd2, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 8'd10, 20'd0, 1, 1, 8'd9, 0);
    chk("coincide_old_weight", 32'(o_sum[0]), 32'd20);
    chk("coincide_wav", 32'(o_wav[0]), 32'd1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 8'd1, 20'd0, 0, 0, 0, 0);
    chk("swapped_to_9", 32'(o_sum[0]), 32'd9);
    // Positive overflow: saturate vs wrap
    step(0, 0, 0, 0, 1, 1, 8'd127, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 8'd127, 20'd524287, 0, 0, 0, 0);
    chk("sat_max", 32'(o_sum[0]), 32'h7FFFF);
    chk("sat_ovf", 32'(o_ovf[0]), 32'd1);
    chk("wrap_sum", 32'(o_sum[1]), 32'h83F00);
    chk("wrap_ovf", 32'(o_ovf[1]), 32'd1);
    // Negative overflow clamps to minimum
    step(0, 1, 8'h81, 20'h80000, 0, 0, 0, 0);
    chk("sat_min", 32'(o_sum[0]), 32'h80000);
    // Clear vs set priority
    step(0, 1, 8'd0, 20'd0, 0, 0, 0, 1);
    chk("clear_ovf", 32'(o_ovf[0]), 32'd0);
    step(0, 1, 8'd127, 20'd524287, 0, 0, 0, 1);
    chk("set_beats_clear", 32'(o_ovf[0]), 32'd1);
    // Reset while ACTIVE_PENDING with valid input
    step(0, 0, 0, 0, 1, 0, 8'd33, 0);
    step(1, 1, 8'd50, 20'd1234, 0, 0, 0, 0);
    chk("rst_sum", 32'(o_sum[0]), 32'd0);
    chk("rst_vld", 32'(o_vld[0]), 32'd0);
    chk("rst_wout", 32'(o_wout[0]), 32'd0);
    chk("rst_ovf", 32'(o_ovf[0]), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("rst_swap_ignored", 32'(o_wav[0]), 32'd0);
    // Randomized traffic, biased toward the accumulator extremes
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 3);
      rs  = AW'($urandom);
      if (sel == 1) rs = 20'h7FFFF - AW'($urandom_range(0, 20000));
      if (sel == 2) rs = 20'h80000 + AW'($urandom_range(0, 20000));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, DW'($urandom), rs,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, DW'($urandom),
           $urandom_range(0, 7) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
